csla_pipe: RTL

Parametrised, pipelined carry-select adder: square-root segmentation (RCA + binary-to-excess-1 converter + mux per segment), generalised in width, segment growth and pipeline depth, with carry-in, signed-overflow flag and valid/ready flow control. It sits in the datapath wherever a registered W-bit add is needed and replaces the fixed 32-bit combinational CSLA in new designs.

---
 rtl/csla_pkg.sv | 72 +++++++
 rtl/csla_pipe_if.sv | 30 +++
 rtl/csla_seg.sv | 20 ++
 rtl/csla_pipe.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/csla_pkg.sv
// Segmentation helpers for the pipelined carry-select adder.
// Latency: none (elaboration-time constants and functions only).
// Backpressure: not applicable.
package csla_pkg;

    // Upper bound on segments: W<=64 with every segment at least 2 bits wide.
    localparam int MAX_SEG = 32;

    // Unclipped width of segment i: SEG0, then SEG0+1, SEG0+2 ... capped at smax.
    function automatic int raw_width(input int s0, input int smax, input int i);
        int sw;
        sw = (i == 0) ? s0 : ((s0 + i < smax) ? s0 + i : smax);
        return sw;
    endfunction

    // Number of segments needed to cover w bits; the last one may be clipped.
    function automatic int seg_count(input int w, input int s0, input int smax);
        int n;
        int lsb;
        n   = 0;
        lsb = 0;
        for (int i = 0; i < MAX_SEG; i++) begin
            if (lsb < w) begin
                lsb += raw_width(s0, smax, i);
                n++;
            end
        end
        return n;
    endfunction

    // Bit index of the LSB of segment k.
    function automatic int seg_lsb(input int w, input int s0, input int smax, input int k);
        int lsb;
        lsb = 0;
        for (int i = 0; i < MAX_SEG; i++) begin
            if (i < k) begin
                lsb += raw_width(s0, smax, i);
            end
        end
        if (lsb > w) begin
            lsb = w;
        end
        return lsb;
    endfunction

    // Width of segment k; the last segment takes whatever bits remain.
    function automatic int seg_width(input int w, input int s0, input int smax, input int k);
        int lsb;
        int sw;
        lsb = seg_lsb(w, s0, smax, k);
        sw  = raw_width(s0, smax, k);
        if (lsb + sw > w) begin
            sw = w - lsb;
        end
        return sw;
    endfunction

    // Last segment computed ahead of the stage-1 register in the two-stage build.
    // Clamped so at least one segment is left for stage 2.
    function automatic int split_seg(input int nseg);
        int s;
        s = nseg / 2;
        if (s > nseg - 2) begin
            s = nseg - 2;
        end
        if (s < 0) begin
            s = 0;
        end
        return s;
    endfunction

endpackage

// File: rtl/csla_pipe_if.sv
// Operand/result bundle for csla_pipe: valid/ready in, valid/ready out.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready carried alongside the data they qualify.
interface csla_pipe_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    // Producer/consumer side of the adder.
    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/csla_seg.sv
// One carry-select segment: N-bit RCA with cin=0, (N+1)-bit +1 converter, select mux.
// Latency: combinational.
// Backpressure: none.
module csla_seg #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sel,
    output logic [N-1:0] s,
    output logic         c
);
    logic [N:0] r0;
    logic [N:0] r1;

    // Carry-in-0 result and its +1 (carry-in-1) version; sel picks one.
    assign r0     = {1'b0, a} + {1'b0, b};
    assign r1     = r0 + {{N{1'b0}}, 1'b1};
    assign {c, s} = sel ? r1 : r0;
endmodule

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder with cin, carry-out and signed overflow; CSLA_PIPE_SUB_EN adds op=1 subtract.
// Latency: STAGES (1 or 2) cycles from accepting edge to out_valid.
// Backpressure: each stage refills as it drains; in_ready drops combinationally when out_ready is low on a full pipe.
module csla_pipe
    import csla_pkg::*;
#(
    parameter int W       = 32,
    parameter int SEG0    = 3,
    parameter int SEG_MAX = 7,
    parameter int STAGES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    csla_pipe_if.slave bus
);
    localparam int NSEG  = seg_count(W, SEG0, SEG_MAX);
    localparam int SPLIT = split_seg(NSEG);
    localparam int LOW_W = seg_lsb(W, SEG0, SEG_MAX, SPLIT + 1);
    localparam int HI_W  = W - LOW_W;

    // Stage-1 payload: finished low sum, its carry-out, upper operand slices still to add.
    typedef struct packed {
        logic [LOW_W-1:0] lo;
        logic             c;
        logic [HI_W-1:0]  ah;
        logic [HI_W-1:0]  bh;
    } s1_t;

    logic         s1_valid;
    s1_t          s1_q;
    logic         s1_leaves;
    logic         in_ready;
    logic         out_free;
    logic         out_load;
    logic         out_valid_q;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;

    logic [W-1:0] b_in;
    logic         cin_in;
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    logic [W-1:0] s_comb;
    logic         cy [0:NSEG];
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_ovf;

`ifdef CSLA_PIPE_SUB_EN
    // Subtract as a + ~b + 1.
    assign b_in   = bus.op ? ~bus.b : bus.b;
    assign cin_in = bus.op | bus.cin;
`else
    logic unused_op;
    assign unused_op = bus.op;
    assign b_in      = bus.b;
    assign cin_in    = bus.cin;
`endif

    // Lower segments always see the live operands; upper segments see the
    // stage-1 copies when the add is split across two registers.
    assign xa = (STAGES == 2) ? {s1_q.ah, bus.a[LOW_W-1:0]} : bus.a;
    assign xb = (STAGES == 2) ? {s1_q.bh, b_in[LOW_W-1:0]}  : b_in;

    assign cy[0] = cin_in;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int LSB = seg_lsb(W, SEG0, SEG_MAX, k);
        localparam int SW  = seg_width(W, SEG0, SEG_MAX, k);
        if (k == 0) begin : g_rca
            assign {cy[1], s_comb[SW-1:0]} = {1'b0, xa[SW-1:0]} + {1'b0, xb[SW-1:0]}
                                             + {{SW{1'b0}}, cy[0]};
        end else begin : g_csel
            logic sel;
            // First stage-2 segment selects on the registered low carry.
            assign sel = (STAGES == 2 && k == SPLIT + 1) ? s1_q.c : cy[k];
            csla_seg #(.N(SW)) u_seg (
                .a   (xa[LSB +: SW]),
                .b   (xb[LSB +: SW]),
                .sel (sel),
                .s   (s_comb[LSB +: SW]),
                .c   (cy[k+1])
            );
        end
    end

    assign res_sum  = (STAGES == 2) ? {s_comb[W-1:LOW_W], s1_q.lo} : s_comb;
    assign res_cout = cy[NSEG];
    // Carry into the MSB recovered from the MSB sum bit, then compared with cout.
    assign res_ovf  = (xa[W-1] ^ xb[W-1] ^ s_comb[W-1]) ^ cy[NSEG];

    // Handshake: a stage loads when its upstream is valid and it is empty or draining.
    assign out_free  = !out_valid_q || bus.out_ready;
    assign s1_leaves = s1_valid && out_free;
    assign in_ready  = (STAGES == 2) ? (!s1_valid || s1_leaves) : out_free;
    assign out_load  = ((STAGES == 2) ? s1_valid : bus.in_valid) && out_free;

    if (STAGES == 2) begin : g_s1
        // Stage-1 register: capture low half result and upper operand slices.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_q     <= '0;
            end else begin
                if (in_ready) begin
                    s1_valid <= bus.in_valid;
                end
                if (bus.in_valid && in_ready) begin
                    s1_q.lo <= s_comb[LOW_W-1:0];
                    s1_q.c  <= cy[SPLIT+1];
                    s1_q.ah <= bus.a[W-1:LOW_W];
                    s1_q.bh <= b_in[W-1:LOW_W];
                end
            end
        end
    end else begin : g_no_s1
        assign s1_valid = 1'b0;
        assign s1_q     = '0;
    end

    // Output register: holds the result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (out_free) begin
                out_valid_q <= out_load;
            end
            if (out_load) begin
                sum_q  <= res_sum;
                cout_q <= res_cout;
                ovf_q  <= res_ovf;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
